// File: rtl/bus_trace_card.sv
// Passive backplane trace card: samples the SUBLEQ data/addr/ctrl bus into a
// circular buffer, triggers on a masked address/control match, then freezes.
module bus_trace_card #(
   parameter int DATAWIDTH = 16,
   parameter int CTRLWIDTH = 14,
   parameter int DEPTH     = 32,
   parameter int IDXW      = 5
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [DATAWIDTH-1:0]            data,
   input  logic [DATAWIDTH-1:0]            addr,
   input  logic [CTRLWIDTH-1:0]            ctrl,
   input  logic                            arm,
   input  logic                            abort,
   input  logic [DATAWIDTH-1:0]            trig_addr,
   input  logic [DATAWIDTH-1:0]            trig_amask,
   input  logic [CTRLWIDTH-1:0]            trig_ctrl,
   input  logic [CTRLWIDTH-1:0]            trig_cmask,
   input  logic [IDXW-1:0]                 post_count,
   input  logic                            rd_en,
   input  logic [IDXW-1:0]                 rd_idx,
   output logic [CTRLWIDTH+2*DATAWIDTH-1:0] rd_data,
   output logic                            rd_valid,
   output logic                            rd_err,
   output logic                            armed,
   output logic                            done,
   output logic [IDXW-1:0]                 trig_index,
   output logic [IDXW:0]                   fill
);

   localparam int EW = CTRLWIDTH + 2 * DATAWIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

   state_t          state, state_nx;
   logic [EW-1:0]   mem [DEPTH];
   logic [IDXW-1:0] wr_ptr;
   logic [IDXW-1:0] remaining;
   logic [IDXW-1:0] base;
   logic [IDXW-1:0] phys;
   logic [IDXW:0]   fill_inc;
   logic            match;
   logic            wr_en;
   logic            full;
   logic            rd_ok;

   assign full     = (fill == (IDXW+1)'(DEPTH));
   assign fill_inc = full ? fill : fill + 1'b1;
   assign match    = (((addr ^ trig_addr) & trig_amask) == '0) &&
                     (((ctrl ^ trig_ctrl) & trig_cmask) == '0);
   // Once the buffer has wrapped, the oldest retained sample sits at wr_ptr.
   assign base     = full ? wr_ptr : '0;
   assign phys     = base + rd_idx;
   assign rd_ok    = rd_en && (state == S_DONE);

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      if (abort) begin
         state_nx = S_IDLE;
      end else if (arm) begin
         state_nx = S_ARMED;
      end else begin
         case (state)
            S_ARMED: begin
               wr_en = 1'b1;
               if (match) state_nx = (post_count == '0) ? S_DONE : S_POST;
            end
            S_POST: begin
               wr_en = 1'b1;
               if (remaining == IDXW'(1)) state_nx = S_DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {ctrl, addr, data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         armed      <= 1'b0;
         done       <= 1'b0;
         wr_ptr     <= '0;
         fill       <= '0;
         trig_index <= '0;
         remaining  <= '0;
      end else begin
         state <= state_nx;
         armed <= (state_nx == S_ARMED) || (state_nx == S_POST);
         done  <= (state_nx == S_DONE);
         if (!abort && arm) begin
            wr_ptr <= '0;
            fill   <= '0;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            fill   <= fill_inc;
            if (state == S_ARMED && match) begin
               trig_index <= IDXW'(fill_inc - 1'b1);
               remaining  <= post_count;
            end
            if (state == S_POST) begin
               remaining <= remaining - 1'b1;
               // Overwriting the oldest entry shifts every logical index down.
               if (full && trig_index != '0) trig_index <= trig_index - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) begin
            if ({1'b0, rd_idx} >= fill) begin
               rd_data <= '0;
               rd_err  <= 1'b1;
            end else begin
               rd_data <= mem[phys];
               rd_err  <= 1'b0;
            end
         end else begin
            rd_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bus_trace_card.sv
// Bench for bus_trace_card: directed scenarios plus randomized capture runs,
// all checked against a queue-based model of the retained trace.
module tb_bus_trace_card;

   localparam int DW    = 16;
   localparam int CW    = 14;
   localparam int DEPTH = 32;
   localparam int IDXW  = 5;
   localparam int EW    = CW + 2 * DW;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [DW-1:0]   data = '0, addr = '0;
   logic [CW-1:0]   ctrl = '0;
   logic            arm = 1'b0, abort = 1'b0;
   logic [DW-1:0]   trig_addr = '0, trig_amask = '0;
   logic [CW-1:0]   trig_ctrl = '0, trig_cmask = '0;
   logic [IDXW-1:0] post_count = '0;
   logic            rd_en = 1'b0;
   logic [IDXW-1:0] rd_idx = '0;
   logic [EW-1:0]   rd_data;
   logic            rd_valid, rd_err, armed, done;
   logic [IDXW-1:0] trig_index;
   logic [IDXW:0]   fill;

   bus_trace_card #(.DATAWIDTH(DW), .CTRLWIDTH(CW), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
      .clk(clk), .rst_n(rst_n), .data(data), .addr(addr), .ctrl(ctrl),
      .arm(arm), .abort(abort), .trig_addr(trig_addr), .trig_amask(trig_amask),
      .trig_ctrl(trig_ctrl), .trig_cmask(trig_cmask), .post_count(post_count),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_err(rd_err), .armed(armed), .done(done), .trig_index(trig_index),
      .fill(fill)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: 0 idle, 1 armed, 2 post, 3 done; hist[0] is the oldest retained sample.
   int            m_st = 0;
   logic [EW-1:0] hist[$];
   int            e_trig = 0;
   int            rem = 0;
   logic          e_rv = 1'b0, e_err = 1'b0;
   logic [EW-1:0] e_data = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0;
      hist.delete();
      e_trig = 0;
      e_rv = 1'b0;
   endtask

   task automatic model_step();
      logic [EW-1:0] s;
      bit            dropped;
      bit            hit;
      s   = {ctrl, addr, data};
      hit = (((addr ^ trig_addr) & trig_amask) == 0) && (((ctrl ^ trig_ctrl) & trig_cmask) == 0);
      e_rv = 1'b0;
      if (rd_en && m_st == 3) begin
         e_rv = 1'b1;
         if (int'(rd_idx) >= hist.size()) begin
            e_err = 1'b1;
            e_data = '0;
         end else begin
            e_err = 1'b0;
            e_data = hist[rd_idx];
         end
      end
      if (abort) m_st = 0;
      else if (arm) begin
         m_st = 1;
         hist.delete();
      end else if (m_st == 1 || m_st == 2) begin
         hist.push_back(s);
         dropped = 1'b0;
         if (hist.size() > DEPTH) begin
            void'(hist.pop_front());
            dropped = 1'b1;
         end
         if (m_st == 1) begin
            if (hit) begin
               e_trig = hist.size() - 1;
               rem = int'(post_count);
               m_st = (post_count == 0) ? 3 : 2;
            end
         end else begin
            if (dropped && e_trig > 0) e_trig--;
            rem--;
            if (rem == 0) m_st = 3;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("armed", 64'(armed), 64'(m_st == 1 || m_st == 2));
      chk("done", 64'(done), 64'(m_st == 3));
      chk("fill", 64'(fill), 64'(hist.size()));
      chk("rd_valid", 64'(rd_valid), 64'(e_rv));
      if (e_rv) begin
         chk("rd_err", 64'(rd_err), 64'(e_err));
         chk("rd_data", 64'(rd_data), 64'(e_data));
      end
      if (m_st == 3) chk("trig_index", 64'(trig_index), 64'(e_trig));
   endtask

   // mode 0: addr counts k; mode 1: ctrl bit 3 set from k>=4; mode 2: fully random
   task automatic drive_bus(input int k, input int mode);
      data = 16'($urandom);
      ctrl = 14'($urandom);
      addr = (mode == 0) ? 16'(k) : 16'($urandom);
      if (mode == 1) ctrl[3] = (k >= 4);
   endtask

   task automatic set_trig(input logic [DW-1:0] a, input logic [DW-1:0] am,
                           input logic [CW-1:0] c, input logic [CW-1:0] cm,
                           input logic [IDXW-1:0] pc);
      trig_addr = a; trig_amask = am; trig_ctrl = c; trig_cmask = cm; post_count = pc;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   // Captures counting samples until done or the budget runs out.
   task automatic capture(input int mode, input int budget, output int k);
      k = 0;
      while (!done && k < budget) begin
         drive_bus(k, mode);
         tick();
         k++;
      end
      if (!done) chk("capture_timeout", 64'(done), 64'(1));
   endtask

   task automatic read_at(input int idx);
      rd_en = 1'b1;
      rd_idx = IDXW'(idx);
      tick();
   endtask

   task automatic run_to(input int n);
      for (int i = 0; i < n; i++) begin
         drive_bus(i, 0);
         tick();
      end
   endtask

   int k;

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_fill", 64'(fill), 64'(0));
      chk("rst_armed", 64'(armed), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rd_data", 64'(rd_data), 64'(0));
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      rst_n = 1'b1;
      tick();

      // Basic capture, including a read attempt while still armed
      set_trig(16'h0010, 16'hFFFF, '0, '0, 5'd3);
      do_arm();
      rd_en = 1'b1;
      rd_idx = 5'd0;
      drive_bus(0, 0);
      tick();
      chk("rd_in_armed", 64'(rd_valid), 64'(0));
      rd_en = 1'b0;
      k = 1;
      while (!done && k < 100) begin
         drive_bus(k, 0);
         tick();
         k++;
      end
      chk("basic_last_k", 64'(k), 64'(20));
      chk("basic_fill", 64'(fill), 64'(20));
      chk("basic_trig", 64'(trig_index), 64'(16));
      read_at(16);
      chk("basic_rd16", 64'(rd_data[2*DW-1:DW]), 64'h0010);
      read_at(19);
      chk("basic_rd19", 64'(rd_data[2*DW-1:DW]), 64'h0013);
      read_at(25);
      chk("basic_rd25_err", 64'(rd_err), 64'(1));
      chk("basic_rd25_data", 64'(rd_data), 64'(0));
      rd_en = 1'b0;
      tick();

      // Wrap
      set_trig(16'h0040, 16'hFFFF, '0, '0, 5'd8);
      do_arm();
      capture(0, 200, k);
      chk("wrap_fill", 64'(fill), 64'(32));
      chk("wrap_trig", 64'(trig_index), 64'(23));
      read_at(0);
      chk("wrap_rd0", 64'(rd_data[2*DW-1:DW]), 64'h0029);
      read_at(31);
      chk("wrap_rd31", 64'(rd_data[2*DW-1:DW]), 64'h0048);
      rd_en = 1'b0;
      tick();

      // Masks: address ignored, ctrl bit 3 only, post_count 0
      set_trig('0, '0, 14'h0008, 14'h0008, 5'd0);
      do_arm();
      capture(1, 50, k);
      chk("mask_k", 64'(k), 64'(5));
      chk("mask_trig", 64'(trig_index), 64'(4));
      chk("mask_fill", 64'(fill), 64'(5));

      // Priority: arm+abort in POST goes idle; arm alone restarts
      set_trig(16'h0010, 16'hFFFF, '0, '0, 5'd10);
      do_arm();
      run_to(18);
      arm = 1'b1;
      abort = 1'b1;
      tick();
      arm = 1'b0;
      abort = 1'b0;
      chk("prio_both_armed", 64'(armed), 64'(0));
      chk("prio_both_done", 64'(done), 64'(0));
      do_arm();
      run_to(18);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("prio_arm_armed", 64'(armed), 64'(1));
      chk("prio_arm_fill0", 64'(fill), 64'(0));
      drive_bus(0, 0);
      tick();
      chk("prio_arm_fill1", 64'(fill), 64'(1));

      // Asynchronous reset mid-POST
      run_to(18);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_armed", 64'(armed), 64'(0));
      chk("arst_done", 64'(done), 64'(0));
      chk("arst_fill", 64'(fill), 64'(0));
      chk("arst_trig", 64'(trig_index), 64'(0));
      chk("arst_rd", 64'({rd_valid, rd_err, rd_data}), 64'(0));
      rst_n = 1'b1;
      tick();

      // Randomized runs
      for (int it = 0; it < 25; it++) begin
         set_trig(16'($urandom), 16'($urandom & $urandom & $urandom),
                  14'($urandom), 14'($urandom & $urandom & $urandom), 5'($urandom));
         do_arm();
         for (int c = 0; c < 200 && m_st != 3; c++) begin
            drive_bus(c, 2);
            rd_en = ($urandom_range(0, 3) == 0);
            rd_idx = 5'($urandom);
            abort = ($urandom_range(0, 150) == 0);
            arm = !abort && ($urandom_range(0, 120) == 0);
            tick();
         end
         abort = 1'b0;
         arm = 1'b0;
         for (int r = 0; r < 40; r++) begin
            rd_en = ($urandom_range(0, 4) != 0);
            rd_idx = 5'($urandom);
            drive_bus(r, 2);
            tick();
         end
         rd_en = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_trace_card.md
Name: bus_trace_card

Overview:
Parametrised backplane logic-analyser card for the SUBLEQ machine. It passively samples the shared data/addr/ctrl bus on every rising clk edge into a circular trace buffer. Capture is armed, triggered on a masked address/control match, and stopped after a programmable post-trigger count. Benches and debug logic read the frozen trace back through a registered index port. It never drives the bus.

Parameters:
DATAWIDTH, 16, width of data and addr bus
CTRLWIDTH, 14, width of ctrl bus
DEPTH, 32, trace entries; power of two, >=4
IDXW, 5, log2(DEPTH)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
data  input  DATAWIDTH  bus data, sampled only
addr  input  DATAWIDTH  bus address, sampled only
ctrl  input  CTRLWIDTH  bus control lines, sampled only
arm  input  1  pulse: clear trace, start capture
abort  input  1  pulse: return to IDLE
trig_addr  input  DATAWIDTH  address compare value
trig_amask  input  DATAWIDTH  address compare mask (1 = bit compared)
trig_ctrl  input  CTRLWIDTH  ctrl compare value
trig_cmask  input  CTRLWIDTH  ctrl compare mask
post_count  input  IDXW  samples captured after the trigger sample
rd_en  input  1  readout request
rd_idx  input  IDXW  logical index; 0 = oldest retained sample
rd_data  output  CTRLWIDTH+2*DATAWIDTH  {ctrl,addr,data} of requested entry
rd_valid  output  1  rd_data valid, one cycle after rd_en
rd_err  output  1  with rd_valid: rd_idx >= fill
armed  output  1  state is ARMED or POST
done  output  1  state is DONE
trig_index  output  IDXW  logical index of the trigger sample
fill  output  IDXW+1  valid entries, 0..DEPTH

Behaviour:
- Reset (rst_n low, async): state IDLE; wr_ptr, fill, trig_index, remaining = 0; rd_data = 0; rd_valid, rd_err, armed, done = 0. Buffer contents not reset. Reset mid-capture discards the trace.
- match = ((addr ^ trig_addr) & trig_amask) == 0 AND ((ctrl ^ trig_ctrl) & trig_cmask) == 0. All-zero masks trigger on the first captured sample.
- Priority per cycle: abort > arm > state action.
- IDLE: no writes. arm -> ARMED; wr_ptr = 0, fill = 0.
- ARMED: each cycle write {ctrl,addr,data} at wr_ptr, wr_ptr = wr_ptr+1 mod DEPTH, fill = min(fill+1, DEPTH). The arm cycle itself is not captured; first sample is the edge after arm.
- On match in ARMED: the matching sample is written; trig_index = logical index of that sample after this write; remaining = post_count. post_count = 0 -> DONE, else -> POST.
- POST: write each cycle as above, trig_index decremented by 1 (floor 0) whenever fill is already DEPTH (oldest entry overwritten). remaining decrements; write made with remaining = 1 -> DONE.
- DONE: no writes; done = 1; buffer frozen. arm restarts (-> ARMED, clears fill).
- arm in ARMED/POST restarts capture identically to arm from IDLE.
- Wrap: while fill = DEPTH, oldest entry is at wr_ptr; else at 0. Physical address = (base + rd_idx) mod DEPTH.
- Readout: accepted only in DONE. rd_en at edge N -> rd_valid = 1 for edge N+1 only. rd_idx >= fill -> rd_data = 0, rd_err = 1. rd_en in other states -> rd_valid stays 0. Back-to-back rd_en gives one result per cycle.
- armed/done are registered state decodes.

Test Plan:
- Reset: rst_n low mid-POST -> all outputs 0 immediately, state IDLE, fill = 0.
- Basic: DEPTH 32, trig_addr 0x0010 mask 0xFFFF, post_count 3, bus addr counts 0x0000 up each cycle from arm+1 -> done after sample 0x0013; fill = 20, trig_index = 16, rd_idx 16 -> addr 0x0010, rd_idx 19 -> 0x0013.
- Wrap: trigger at addr 0x0040, post_count 8 -> fill = 32, rd_idx 0 -> addr 0x0029, rd_idx 31 -> 0x0048, trig_index = 23.
- Masks: trig_amask 0, trig_cmask selects ctrl bit 3 = 1, bit 3 first set on 5th sample -> trig_index = 4, post_count 0 -> done same edge.
- Readout rules: rd_idx 25 with fill 20 -> rd_valid 1, rd_err 1, rd_data 0; rd_en while ARMED -> rd_valid 0.
- Priority: arm and abort same cycle in POST -> IDLE; arm alone in POST -> ARMED, fill back to 0, then 1 next edge.
